// File: rtl/data_mem_responder.sv
// Slave end of the pipeline load/store port: one request at a time, fixed-latency
// access to a 64-bit word array, load data / store ack with error reporting.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [63:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic [63:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] ADDR_LIMIT = DW'(DEPTH) * DW'(8);
  localparam logic [CW-1:0] CNT_LAST   = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;

  logic          req_we_q;
  logic [DW-1:0] req_addr_q;
  logic [2:0]    req_funct3_q;
  logic [DW-1:0] req_wdata_q;

  logic          resp_valid_d, resp_err_d, ready_d, busy_d;
  logic [DW-1:0] resp_rdata_d;

  logic [DW-1:0] mem [DEPTH];

  // Access decode on the captured request
  logic [2:0]    off;
  logic [AW-1:0] word_idx;
  logic [1:0]    size;
  logic [5:0]    shamt;
  logic          misalign, bad_funct3, out_of_range, req_err;
  logic [DW-1:0] rd_shift, load_ext, wdata_sh;
  logic [7:0]    lane_mask;
  logic          sign;
  logic          store_commit;

  assign off      = req_addr_q[2:0];
  assign word_idx = req_addr_q[3 +: AW];
  assign size     = req_funct3_q[1:0];
  assign shamt    = {off, 3'b000};
  assign sign     = ~req_funct3_q[2];

  always_comb begin
    misalign  = 1'b0;
    lane_mask = 8'h01;
    unique case (size)
      2'b00: begin misalign = 1'b0;        lane_mask = 8'h01; end
      2'b01: begin misalign = off[0];      lane_mask = 8'h03; end
      2'b10: begin misalign = |off[1:0];   lane_mask = 8'h0F; end
      default: begin misalign = |off;      lane_mask = 8'hFF; end
    endcase
    lane_mask = lane_mask << off;
  end

  assign bad_funct3   = req_we_q ? req_funct3_q[2] : (req_funct3_q == 3'b111);
  assign out_of_range = (req_addr_q >= ADDR_LIMIT);
  assign req_err      = misalign | bad_funct3 | out_of_range;

  assign rd_shift = mem[word_idx] >> shamt;
  assign wdata_sh = req_wdata_q << shamt;

  always_comb begin
    load_ext = rd_shift;
    unique case (size)
      2'b00:   load_ext = {{56{sign & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_ext = {{48{sign & rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   load_ext = {{32{sign & rd_shift[31]}}, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  assign store_commit = (state_q == WAIT) && (cnt_q == CNT_LAST) && req_we_q && !req_err;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    resp_valid_d = o_resp_valid;
    resp_rdata_d = o_resp_rdata;
    resp_err_d   = o_resp_err;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = req_err;
          resp_rdata_d = (req_err || req_we_q) ? '0 : load_ext;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_funct3_q <= '0;
      req_wdata_q  <= '0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
      o_req_ready  <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_resp_valid <= resp_valid_d;
      o_resp_rdata <= resp_rdata_d;
      o_resp_err   <= resp_err_d;
      o_req_ready  <= ready_d;
      o_busy       <= busy_d;
      if (capture) begin
        req_we_q     <= i_req_we;
        req_addr_q   <= i_req_addr;
        req_funct3_q <= i_req_funct3;
        req_wdata_q  <= i_req_wdata;
      end
    end
  end

  // Array is never reset; writes are gated by state so a reset mid-op drops the store
  always_ff @(posedge i_clk) begin
    if (store_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (lane_mask[b]) mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned LATENCY = 2;
  localparam logic [63:0] LIMIT   = 64'(DEPTH * 8);

  logic        i_clk, i_resetn;
  logic        i_req_valid, o_req_ready, i_req_we;
  logic [63:0] i_req_addr, i_req_wdata;
  logic [2:0]  i_req_funct3;
  logic        o_resp_valid, i_resp_ready, o_resp_err, o_busy;
  logic [63:0] o_resp_rdata;

  int unsigned n_cmp, n_bad;
  logic [7:0]  ref_mem [DEPTH*8];

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_funct3 (i_req_funct3),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: size = 1<<funct3[1:0], little-endian, arithmetic sign extension
  function automatic void ref_access(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                                     input logic [63:0] wdata, output logic [63:0] rdata,
                                     output logic err);
    int unsigned nb;
    nb    = 1 << f3[1:0];
    err   = (we ? f3[2] : (f3 == 3'd7)) || (addr >= LIMIT) || ((addr % 64'(nb)) != 0);
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(nb); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < int'(nb); i++) rdata = rdata | (64'(ref_mem[int'(addr) + i]) << (8*i));
      if (!f3[2] && nb < 8 && rdata[8*nb-1]) rdata = rdata - (64'd1 << (8*nb));
    end
  endfunction

  // One full transaction, entered and left at posedge+1
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                        input logic [63:0] wdata, input int hold, input string tag);
    logic [63:0] exp_rd;
    logic        exp_err;
    int          cyc;
    ref_access(we, addr, f3, wdata, exp_rd, exp_err);
    chk($sformatf("%s ready_idle @%0h", tag, addr), 64'(o_req_ready), 64'd1);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_addr   = addr;
    i_req_funct3 = f3;
    i_req_wdata  = wdata;
    @(posedge i_clk); #1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'($urandom_range(0, 1));
    i_req_addr   = {$urandom(), $urandom()};
    i_req_funct3 = 3'($urandom_range(0, 7));
    i_req_wdata  = {$urandom(), $urandom()};
    chk($sformatf("%s busy @%0h", tag, addr), 64'(o_busy), 64'd1);
    cyc = 0;
    while (!o_resp_valid && cyc < 40) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    chk($sformatf("%s latency @%0h", tag, addr), 64'(cyc), 64'(LATENCY));
    chk($sformatf("%s rdata @%0h f3=%0d we=%0b", tag, addr, f3, we), o_resp_rdata, exp_rd);
    chk($sformatf("%s err @%0h f3=%0d we=%0b", tag, addr, f3, we), 64'(o_resp_err), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      i_req_valid = 1'b1;
      @(posedge i_clk); #1;
      chk($sformatf("%s hold valid", tag), 64'(o_resp_valid), 64'd1);
      chk($sformatf("%s hold rdata", tag), o_resp_rdata, exp_rd);
      chk($sformatf("%s hold err", tag), 64'(o_resp_err), 64'(exp_err));
      chk($sformatf("%s hold ready", tag), 64'(o_req_ready), 64'd0);
      chk($sformatf("%s hold busy", tag), 64'(o_busy), 64'd1);
    end
    i_req_valid  = 1'b0;
    i_resp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_resp_ready = 1'b0;
    chk($sformatf("%s resp_drop", tag), 64'(o_resp_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_resetn     = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_addr   = '0;
    i_req_funct3 = '0;
    i_req_wdata  = '0;
    i_resp_ready = 1'b0;
    #3 i_resetn = 1'b0;
    #1;
    chk("rst resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst rdata", o_resp_rdata, 64'd0);
    chk("rst err", 64'(o_resp_err), 64'd0);
    chk("rst busy", 64'(o_busy), 64'd0);
    chk("rst ready", 64'(o_req_ready), 64'd1);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_resetn = 1'b1;
    @(posedge i_clk); #1;

    // Populate the region used by random traffic plus the last word
    for (int w = 0; w < 32; w++) do_req(1'b1, 64'(w * 8), 3'd3, {$urandom(), $urandom()}, 0, "init");
    do_req(1'b1, LIMIT - 64'd8, 3'd3, 64'hA5A5_0000_5A5A_FFFF, 0, "init_top");

    do_req(1'b1, 64'h10, 3'd3, 64'h1122334455667788, 0, "sd");
    do_req(1'b0, 64'h10, 3'd3, '0, 0, "ld");
    do_req(1'b1, 64'h13, 3'd0, 64'h80, 0, "sb");
    do_req(1'b0, 64'h13, 3'd0, '0, 0, "lb");
    do_req(1'b0, 64'h13, 3'd4, '0, 0, "lbu");
    do_req(1'b0, 64'h10, 3'd3, '0, 0, "ld_after_sb");
    do_req(1'b0, 64'h12, 3'd2, '0, 0, "lw_misalign");
    do_req(1'b1, 64'h11, 3'd1, 64'hBEEF, 0, "sh_misalign");
    do_req(1'b0, 64'h10, 3'd3, '0, 0, "ld_unchanged");
    do_req(1'b0, LIMIT, 3'd3, '0, 0, "ld_oor");
    do_req(1'b0, 64'h10, 3'd7, '0, 0, "ld_f3_7");
    do_req(1'b1, 64'h10, 3'd6, 64'hFFFF, 0, "st_f3_1xx");
    do_req(1'b0, LIMIT - 64'd8, 3'd3, '0, 0, "ld_top");
    do_req(1'b0, 64'h10, 3'd3, '0, 5, "hold");

    // Reset during WAIT of a store: outputs clear at once, store is dropped
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_addr   = 64'h20;
    i_req_funct3 = 3'd3;
    i_req_wdata  = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("mid busy", 64'(o_busy), 64'd1);
    #2 i_resetn = 1'b0;
    #1;
    chk("mid_rst resp_valid", 64'(o_resp_valid), 64'd0);
    chk("mid_rst rdata", o_resp_rdata, 64'd0);
    chk("mid_rst err", 64'(o_resp_err), 64'd0);
    chk("mid_rst busy", 64'(o_busy), 64'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_resetn = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst ready", 64'(o_req_ready), 64'd1);
    do_req(1'b0, 64'h20, 3'd3, '0, 0, "ld_after_rst");

    for (int t = 0; t < 200; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [63:0] a;
      int unsigned nb;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      nb = 1 << f3[1:0];
      case ($urandom_range(0, 9))
        0:       a = LIMIT + 64'($urandom_range(0, 63));
        1:       a = {$urandom(), $urandom()};
        2, 3:    a = 64'($urandom_range(0, 255));
        default: a = 64'($urandom_range(0, 255)) & ~64'(nb - 1);
      endcase
      do_req(we, a, f3, {$urandom(), $urandom()}, int'($urandom_range(0, 2)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
